// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared fetch-control definitions: FSM encodings, rewind distances,
// default dispatch budgets and the ISR address helper.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_VCOUNT = 3'd1,
    ST_VHOLD  = 3'd2,
    ST_REWIND = 3'd3,
    ST_FROZEN = 3'd4
  } state_e;

  // Distance back to the oldest un-retired fetch when the freeze hits.
  localparam logic [31:0] REWIND_FROM_VHOLD  = 32'd4;
  localparam logic [31:0] REWIND_FROM_VCOUNT = 32'd12;

  localparam int unsigned ISR_SHIFT_DEF    = 3;
  localparam int unsigned VEC_LIMIT_SV_DEF = 5;
  localparam int unsigned VEC_LIMIT_VV_DEF = 6;
  localparam int unsigned CNT_W_DEF        = 4;

  // ISR entry = trap base + scaled device index, wrapping modulo 2^32.
  function automatic logic [31:0] isr_addr(input logic [31:0] base,
                                           input logic [5:0]  dev,
                                           input int unsigned shift);
    logic [31:0] offs;
    offs = {26'd0, dev} << shift;
    return base + offs;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_vec_freeze_edge.sv
// Rising-edge detector for the vector unit's level freeze.
module vec_freeze_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic freeze_i,
  output logic rise_o
);

  logic freeze_q;

  // Remember last cycle's freeze level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freeze_q <= 1'b0;
    end else begin
      freeze_q <= freeze_i;
    end
  end

  assign rise_o = freeze_i & ~freeze_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencing controller: selects the PC source each cycle,
// gates PC / IF_ID writes, tracks the vector-stall dispatch budget,
// rewinds on vector freeze and marks post-redirect bubbles.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ISR_SHIFT    = ISR_SHIFT_DEF,
  parameter int unsigned VEC_LIMIT_SV = VEC_LIMIT_SV_DEF,
  parameter int unsigned VEC_LIMIT_VV = VEC_LIMIT_VV_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              irq_i,
  input  logic [5:0]        device_id_i,
  input  logic [31:0]       csr_mtvec_i,
  input  logic              branch_taken_ex_mem_i,
  input  logic [31:0]       branch_tgt_ex_mem_i,
  input  logic              bpu_taken_i,
  input  logic [31:0]       bpu_tgt_i,
  input  logic              if_id_freeze_i,
  input  logic              vector_stall_i,
  input  logic              vector_release_i,
  input  logic              vector_freeze_i,
  input  logic              sv_vv_i,
  input  logic [31:0]       pc_cur_i,
  output logic [31:0]       pc_next_o,
  output logic              pc_we_o,
  output logic              if_id_we_o,
  output logic              nop_if_id_o,
  output logic [CNT_W-1:0]  vec_count_o,
  output logic [2:0]        state_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               from_vhold_q, from_vhold_d;
  logic               nop_q, nop_d;

  logic               freeze_rise;
  logic               fetch_ok;
  logic               pc_we_raw;
  logic               if_id_we_raw;
  logic [CNT_W-1:0]   limit;
  logic [CNT_W-1:0]   cnt_inc;

  vec_freeze_edge u_freeze_edge (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .freeze_i (vector_freeze_i),
    .rise_o   (freeze_rise)
  );

  assign limit    = sv_vv_i ? CNT_W'(VEC_LIMIT_SV) : CNT_W'(VEC_LIMIT_VV);
  assign fetch_ok = ((state_q == ST_RUN) || (state_q == ST_VCOUNT)) &&
                    !if_id_freeze_i && !vector_freeze_i;

  // PC source selection by fixed priority: irq, branch, rewind, fetch.
  always_comb begin
    pc_next_o    = pc_cur_i + 32'd4;
    pc_we_raw    = 1'b0;
    if_id_we_raw = 1'b0;
    if (irq_i) begin
      pc_next_o = isr_addr(csr_mtvec_i, device_id_i, ISR_SHIFT);
      pc_we_raw = 1'b1;
    end else if (branch_taken_ex_mem_i) begin
      pc_next_o = branch_tgt_ex_mem_i;
      pc_we_raw = 1'b1;
    end else if (state_q == ST_REWIND) begin
      pc_next_o = pc_cur_i - (from_vhold_q ? REWIND_FROM_VHOLD : REWIND_FROM_VCOUNT);
      pc_we_raw = 1'b1;
    end else if (fetch_ok) begin
      pc_next_o    = bpu_taken_i ? bpu_tgt_i : (pc_cur_i + 32'd4);
      pc_we_raw    = 1'b1;
      if_id_we_raw = 1'b1;
    end else begin
      pc_we_raw    = 1'b0;
      if_id_we_raw = 1'b0;
    end
  end

  // Write enables are forced low while reset is asserted.
  assign pc_we_o    = pc_we_raw & rst_ni;
  assign if_id_we_o = if_id_we_raw & rst_ni;

  // Saturating dispatch count for the current VCOUNT cycle.
  assign cnt_inc = (if_id_we_raw && (cnt_q < limit)) ? (cnt_q + CNT_W'(1)) : cnt_q;

  // Next-state, budget counter, rewind origin and bubble flag.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    from_vhold_d = from_vhold_q;
    nop_d        = nop_q;
    if (irq_i) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      nop_d   = 1'b0;
    end else if (branch_taken_ex_mem_i) begin
      state_d = vector_freeze_i ? ST_FROZEN : ST_RUN;
      cnt_d   = '0;
      nop_d   = 1'b1;
    end else begin
      nop_d = if_id_we_raw ? 1'b0 : nop_q;
      case (state_q)
        ST_RUN: begin
          if (freeze_rise) begin
            state_d      = ST_REWIND;
            from_vhold_d = 1'b0;
          end else if (vector_stall_i) begin
            state_d = ST_VCOUNT;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_VCOUNT: begin
          if (freeze_rise) begin
            state_d      = ST_REWIND;
            from_vhold_d = 1'b0;
          end else if (!vector_stall_i || vector_release_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc >= limit) ? ST_VHOLD : ST_VCOUNT;
          end
        end
        ST_VHOLD: begin
          if (freeze_rise) begin
            state_d      = ST_REWIND;
            from_vhold_d = 1'b1;
          end else if (!vector_stall_i || vector_release_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_VHOLD;
          end
        end
        ST_REWIND: begin
          state_d = ST_FROZEN;
        end
        ST_FROZEN: begin
          if (!vector_freeze_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_FROZEN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      from_vhold_q <= 1'b0;
      nop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      from_vhold_q <= from_vhold_d;
      nop_q        <= nop_d;
    end
  end

  assign nop_if_id_o = nop_q;
  assign vec_count_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        irq;
  logic [5:0]  device_id;
  logic [31:0] csr_mtvec;
  logic        br_taken;
  logic [31:0] br_tgt;
  logic        bpu_taken;
  logic [31:0] bpu_tgt;
  logic        if_id_freeze;
  logic        vec_stall;
  logic        vec_release;
  logic        vec_freeze;
  logic        sv_vv;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        if_id_we;
  logic        nop_if_id;
  logic [3:0]  vec_count;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int fetches;

  localparam logic [2:0] RUN = 3'd0, VCOUNT = 3'd1, VHOLD = 3'd2,
                         REWIND = 3'd3, FROZEN = 3'd4;

  fetch_redirect_ctrl dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .irq_i                 (irq),
    .device_id_i           (device_id),
    .csr_mtvec_i           (csr_mtvec),
    .branch_taken_ex_mem_i (br_taken),
    .branch_tgt_ex_mem_i   (br_tgt),
    .bpu_taken_i           (bpu_taken),
    .bpu_tgt_i             (bpu_tgt),
    .if_id_freeze_i        (if_id_freeze),
    .vector_stall_i        (vec_stall),
    .vector_release_i      (vec_release),
    .vector_freeze_i       (vec_freeze),
    .sv_vv_i               (sv_vv),
    .pc_cur_i              (pc_cur),
    .pc_next_o             (pc_next),
    .pc_we_o               (pc_we),
    .if_id_we_o            (if_id_we),
    .nop_if_id_o           (nop_if_id),
    .vec_count_o           (vec_count),
    .state_o               (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge so combinational outputs are settled.
  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; irq = 1'b0; device_id = 6'd0; csr_mtvec = 32'd0;
    br_taken = 1'b0; br_tgt = 32'd0; bpu_taken = 1'b0; bpu_tgt = 32'd0;
    if_id_freeze = 1'b0; vec_stall = 1'b0; vec_release = 1'b0;
    vec_freeze = 1'b0; sv_vv = 1'b1; pc_cur = 32'h100;

    // Reset values
    settle();
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_if_id_we", {31'd0, if_id_we}, 32'd0);
    chk("rst_state", {29'd0, state}, {29'd0, RUN});
    chk("rst_cnt", {28'd0, vec_count}, 32'd0);
    chk("rst_nop", {31'd0, nop_if_id}, 32'd0);
    step();
    rst_n = 1'b1;

    // Idle sequential fetch
    settle();
    chk("idle_pc_next", pc_next, 32'h104);
    chk("idle_pc_we", {31'd0, pc_we}, 32'd1);
    chk("idle_if_id_we", {31'd0, if_id_we}, 32'd1);
    step();
    chk("idle_nop", {31'd0, nop_if_id}, 32'd0);
    chk("idle_state", {29'd0, state}, {29'd0, RUN});

    // BPU redirect, then branch overriding it
    bpu_taken = 1'b1; bpu_tgt = 32'h2000;
    settle();
    chk("bpu_pc_next", pc_next, 32'h2000);
    br_taken = 1'b1; br_tgt = 32'h3000;
    settle();
    chk("br_pc_next", pc_next, 32'h3000);
    chk("br_pc_we", {31'd0, pc_we}, 32'd1);
    step();
    br_taken = 1'b0; bpu_taken = 1'b0;
    chk("br_nop_set", {31'd0, nop_if_id}, 32'd1);
    chk("br_state", {29'd0, state}, {29'd0, RUN});
    step();
    chk("nop_clear_on_fetch", {31'd0, nop_if_id}, 32'd0);

    // Scalar-vector budget of 5
    sv_vv = 1'b1; vec_stall = 1'b1;
    step();
    chk("sv_enter_vcount", {29'd0, state}, {29'd0, VCOUNT});
    chk("sv_cnt_start", {28'd0, vec_count}, 32'd0);
    fetches = 0;
    for (int i = 0; i < 20 && state == VCOUNT; i++) begin
      settle();
      if (if_id_we) fetches++;
      step();
    end
    chk("sv_fetch_count", fetches, 32'd5);
    chk("sv_state_vhold", {29'd0, state}, {29'd0, VHOLD});
    chk("sv_cnt_limit", {28'd0, vec_count}, 32'd5);
    settle();
    chk("vhold_no_fetch", {30'd0, pc_we, if_id_we}, 32'd0);
    vec_release = 1'b1;
    step();
    vec_release = 1'b0; vec_stall = 1'b0;
    chk("release_state", {29'd0, state}, {29'd0, RUN});
    chk("release_cnt", {28'd0, vec_count}, 32'd0);

    // Freeze rewind from VCOUNT
    vec_stall = 1'b1;
    step();
    step();
    chk("fz_pre_state", {29'd0, state}, {29'd0, VCOUNT});
    pc_cur = 32'h200; vec_freeze = 1'b1;
    settle();
    chk("fz_edge_no_fetch", {31'd0, pc_we}, 32'd0);
    step();
    vec_stall = 1'b0;
    chk("rw_state", {29'd0, state}, {29'd0, REWIND});
    settle();
    chk("rw_pc_next", pc_next, 32'h1F4);
    chk("rw_we", {30'd0, pc_we, if_id_we}, 32'd2);
    step();
    chk("frozen_state", {29'd0, state}, {29'd0, FROZEN});
    step();
    settle();
    chk("frozen_hold", {29'd0, state}, {29'd0, FROZEN});
    chk("frozen_pc_we", {31'd0, pc_we}, 32'd0);
    vec_freeze = 1'b0;
    step();
    chk("thaw_state", {29'd0, state}, {29'd0, RUN});
    chk("thaw_cnt", {28'd0, vec_count}, 32'd0);

    // Vector-vector budget of 6, then freeze rewind from VHOLD
    sv_vv = 1'b0; vec_stall = 1'b1;
    step();
    for (int i = 0; i < 20 && state == VCOUNT; i++) step();
    chk("vv_state_vhold", {29'd0, state}, {29'd0, VHOLD});
    chk("vv_cnt_limit", {28'd0, vec_count}, 32'd6);
    pc_cur = 32'h200; vec_freeze = 1'b1;
    step();
    settle();
    chk("rw_vhold_state", {29'd0, state}, {29'd0, REWIND});
    chk("rw_vhold_pc_next", pc_next, 32'h1FC);
    step();
    vec_freeze = 1'b0; vec_stall = 1'b0;
    step();
    chk("vhold_thaw", {29'd0, state}, {29'd0, RUN});

    // Limit drops below count while in VCOUNT
    sv_vv = 1'b0; vec_stall = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("lim_pre_state", {29'd0, state}, {29'd0, VCOUNT});
    chk("lim_pre_cnt", {28'd0, vec_count}, 32'd5);
    sv_vv = 1'b1;
    step();
    chk("lim_switch_vhold", {29'd0, state}, {29'd0, VHOLD});
    vec_release = 1'b1;
    step();
    vec_release = 1'b0; vec_stall = 1'b0;

    // Freeze rise and branch together: branch wins, straight to FROZEN
    vec_freeze = 1'b1; br_taken = 1'b1; br_tgt = 32'h400;
    settle();
    chk("brfz_pc_next", pc_next, 32'h400);
    step();
    br_taken = 1'b0;
    chk("brfz_state", {29'd0, state}, {29'd0, FROZEN});
    vec_freeze = 1'b0;
    step();
    chk("brfz_nop_held", {31'd0, nop_if_id}, 32'd1);

    // IRQ beats branch, clears bubble flag
    irq = 1'b1; csr_mtvec = 32'h8000_0000; device_id = 6'd5;
    br_taken = 1'b1; br_tgt = 32'h5000;
    settle();
    chk("irq_pc_next", pc_next, 32'h8000_0028);
    chk("irq_we", {30'd0, pc_we, if_id_we}, 32'd2);
    step();
    irq = 1'b0; br_taken = 1'b0;
    chk("irq_state", {29'd0, state}, {29'd0, RUN});
    chk("irq_nop", {31'd0, nop_if_id}, 32'd0);

    // Async reset mid-VCOUNT
    vec_stall = 1'b1;
    step();
    step();
    chk("ar_pre_cnt", {28'd0, vec_count}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_state", {29'd0, state}, {29'd0, RUN});
    chk("ar_cnt", {28'd0, vec_count}, 32'd0);
    chk("ar_pc_we", {31'd0, pc_we}, 32'd0);
    vec_stall = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequencing controller for the instruction-fetch PC datapath. It decides every cycle which source the fetch PC register loads from: IRQ vector, EX_MEM branch resolution, BPU prediction or sequential PC+4. It also decides whether the PC and IF_ID registers advance. It owns the vector-stall dispatch budget, the one-cycle rewind on vector freeze, and NOP injection after a redirect, so the PC datapath itself reduces to registers and adders.

## Interface
Parameters:
- ISR_SHIFT, 3: left shift applied to device_id when forming the ISR address.
- VEC_LIMIT_SV, 5: dispatch budget under vector stall, scalar-vector mode.
- VEC_LIMIT_VV, 6: dispatch budget under vector stall, vector-vector mode.
- CNT_W, 4: width of the dispatch counter.

Ports:
- CLK  in  1  clock, single domain.
- RST_N  in  1  reset, asynchronous, active-low.
- irq  in  1  take interrupt now.
- device_id  in  6  interrupting device index.
- csr_mtvec  in  32  trap vector base.
- branch_taken_ex_mem  in  1  branch resolved taken in EX_MEM.
- branch_tgt_ex_mem  in  32  resolved target.
- bpu_taken  in  1  BPU predicts taken for the IF_ID instruction.
- bpu_tgt  in  32  predicted target.
- if_id_freeze  in  1  downstream hazard freeze.
- vector_stall  in  1  vector unit busy.
- vector_release  in  1  vector unit releases the budget.
- vector_freeze  in  1  level freeze from the vector unit.
- sv_vv  in  1  1 = scalar-vector, 0 = vector-vector.
- pc_cur  in  32  current fetch PC register value.
- pc_next  out  32  value the PC register loads when pc_we is high.
- pc_we  out  1  PC register write enable.
- if_id_we  out  1  IF_ID register write enable.
- nop_if_id  out  1  marks the IF_ID instruction as a bubble.
- vec_count  out  CNT_W  instructions dispatched under the current stall.
- state  out  3  FSM state, for debug.

## Operation
FSM states (encoding 0-4): RUN, VCOUNT, VHOLD, REWIND, FROZEN. limit = sv_vv ? VEC_LIMIT_SV : VEC_LIMIT_VV.

Source priority, evaluated every cycle:
1. irq: pc_next = csr_mtvec + ({26'b0,device_id} << ISR_SHIFT), modulo 2^32. pc_we=1, if_id_we=0. Next state RUN, counter cleared. Overrides every state, FROZEN included.
2. branch_taken_ex_mem: pc_next = branch_tgt_ex_mem, pc_we=1, counter cleared. Next state is FROZEN if vector_freeze is high, else RUN. This applies even when if_id_freeze is high.
3. REWIND: pc_next = pc_cur − (came from VHOLD ? 4 : 12), pc_we=1, if_id_we=0. Next state FROZEN.
4. Fetch allowed (fetch_ok) only when all of the following hold:
   - state is RUN or VCOUNT;
   - if_id_freeze is low;
   - vector_freeze is low.

   When fetch_ok: pc_we = if_id_we = 1, and pc_next = bpu_taken ? bpu_tgt : pc_cur + 4.
5. Otherwise pc_we = if_id_we = 0.

Transitions, when neither irq nor branch applies:
- RUN → VCOUNT on vector_stall=1. Counter starts at 0.
- VCOUNT:
  - counter increments on each cycle where if_id_we=1;
  - when the counter reaches limit, go to VHOLD;
  - on vector_stall=0 or vector_release=1, go to RUN and clear the counter.
- VHOLD: no fetch. On vector_stall=0 or vector_release=1, go to RUN and clear the counter.
- Rising edge of vector_freeze (freeze_d registered) from RUN, VCOUNT or VHOLD → REWIND. Remember whether the source state was VHOLD.
- FROZEN → RUN when vector_freeze=0. Clear the counter.

nop_if_id is registered:
- set to 1 on the cycle after a branch redirect;
- cleared to 0 after an irq redirect;
- otherwise holds its value when if_id_we=0 and loads 0 when if_id_we=1.

## Timing
- Reset values: state=RUN, vec_count=0, nop_if_id=0, freeze_d=0. While RST_N is low, pc_we=0 and if_id_we=0.
- pc_next, pc_we and if_id_we are combinational from inputs, state and counter. There is no extra latency, so a redirect takes effect at the next CLK edge.
- state, vec_count, nop_if_id and freeze_d update on the CLK rising edge.
- The counter saturates at limit and never wraps.
- If sv_vv changes while in VCOUNT, the new limit applies immediately. If the counter is already ≥ the new limit, go to VHOLD next cycle.
- A vector_freeze rising edge in the same cycle as a branch: the branch wins, no REWIND, next state FROZEN.
- irq and branch in the same cycle: irq wins, and the branch target is dropped.
- Asserting RST_N low mid-REWIND abandons the rewind. All state returns to reset values asynchronously.

## Structure
- Shared package (cpu defines): FSM state encodings, rewind constants 4 and 12, and the default limit values.
- A single module. The only natural sub-module is the freeze edge detector, vec_freeze_edge (a flop plus AND). Inline it if preferred.

## Test plan
- Reset then idle: pc_cur=0x100, no events → pc_next=0x104, pc_we=1, if_id_we=1, nop_if_id=0, state=RUN.
- BPU redirect: bpu_taken=1, bpu_tgt=0x2000 → pc_next=0x2000. Adding branch_taken_ex_mem=1 with target 0x3000 in the same cycle → pc_next=0x3000, and nop_if_id=1 the next cycle.
- Vector budget: sv_vv=1 and vector_stall held high → exactly 5 cycles with if_id_we=1, then state=VHOLD and vec_count=5. vector_release=1 → RUN, vec_count=0.
- Freeze rewind from VCOUNT: pc_cur=0x200, vector_freeze rises → one REWIND cycle with pc_next=0x1F4, then FROZEN with pc_we=0 until the freeze drops. From VHOLD the rewind value is pc_cur−4.
- IRQ priority: irq=1, csr_mtvec=0x8000_0000, device_id=5, branch_taken_ex_mem=1 in the same cycle → pc_next=0x8000_0028, state=RUN, nop_if_id=0.
- Async reset mid-VCOUNT: drop RST_N between clock edges → state=RUN and vec_count=0 immediately, without waiting for a clock edge.
